// File: rtl/inst_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_loader_pkg : loader state encodings and frame field size         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package inst_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_LOAD  = 3'd1,
    S_CKSUM = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  localparam int unsigned FIELD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_loader_byte_packer : little-endian byte to WORD-bit word packer  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module inst_loader_byte_packer #(
  parameter int unsigned WORD = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push_i,
  input  logic [7:0]      byte_i,
  output logic [WORD-1:0] word_o,
  output logic            last_o
);

  localparam int unsigned     BYTES    = WORD / 8;
  localparam int unsigned     IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [WORD-1:0]  data_q;
  logic [IDX_W-1:0] idx_q;

  // word_o already contains the byte on the bus, so the final byte is usable this cycle
  always_comb begin
    word_o = data_q;
    word_o[{idx_q, 3'b000} +: 8] = byte_i;
  end

  assign last_o = (idx_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      idx_q  <= '0;
    end else if (push_i) begin
      data_q <= word_o;
      idx_q  <= last_o ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | inst_loader : boot loader, LEN | words | [CKSUM] into instruction mem  |
// | Optional checksum field enabled by INST_LOADER_CKSUM_EN               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned     WORD      = 32,
  parameter int unsigned     ADDR      = 16,
  parameter logic [ADDR-1:0] BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [7:0]      byte_i,
  input  logic            byte_valid_i,
  output logic            byte_ready_o,
  output logic [ADDR-1:0] mem_addr_o,
  output logic [WORD-1:0] mem_data_o,
  output logic            mem_write_o,
  output logic            core_rst_n_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam logic [63:0] LEN_LIMIT  = (64'd1 << ADDR) - 64'(BASE_ADDR);
  localparam logic [1:0]  LAST_FIELD = 2'(FIELD_BYTES - 1);
`ifdef INST_LOADER_CKSUM_EN
  localparam state_e S_AFTER_WORDS = S_CKSUM;
`else
  localparam state_e S_AFTER_WORDS = S_DONE;
`endif

  state_e          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     field_q, field_d;
  logic [31:0]     len_q, len_d;
  logic [31:0]     wcnt_q, wcnt_d;
  logic [31:0]     sum_q, sum_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [WORD-1:0] data_q, data_d;
  logic            write_q, write_d;
  logic            busy_q, err_q, core_q;

  logic            w_xfer, w_push, w_last;
  logic [WORD-1:0] w_word;
  logic [31:0]     w_field, w_word32;

  assign byte_ready_o = busy_q & ~write_q;
  assign w_xfer       = byte_valid_i & byte_ready_o;
  assign w_push       = w_xfer & (state_q == S_LOAD);
  assign w_field      = {byte_i, field_q};

  generate
    if (WORD >= 32) begin : g_sum_trunc
      assign w_word32 = w_word[31:0];
    end else begin : g_sum_ext
      assign w_word32 = {{(32 - WORD){1'b0}}, w_word};
    end
  endgenerate

  inst_loader_byte_packer #(.WORD(WORD)) u_packer (
    .clk    (clk),
    .reset  (reset),
    .push_i (w_push),
    .byte_i (byte_i),
    .word_o (w_word),
    .last_o (w_last)
  );

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    field_d = field_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    sum_d   = sum_q;
    addr_d  = addr_q;
    data_d  = data_q;
    write_d = 1'b0;
    case (state_q)
      S_LEN: begin
        if (w_xfer) begin
          field_d = w_field[31:8];
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == LAST_FIELD) begin
            len_d = w_field;
            if (w_field == '0)                     state_d = S_AFTER_WORDS;
            else if ({32'd0, w_field} > LEN_LIMIT) state_d = S_ERR;
            else                                   state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // the strobe cycle doubles as the bubble: no byte is accepted while writing
        if (write_q) begin
          addr_d = addr_q + ADDR'(1);
          wcnt_d = wcnt_q + 32'd1;
          if (wcnt_d == len_q) state_d = S_AFTER_WORDS;
        end else if (w_xfer && w_last) begin
          write_d = 1'b1;
          data_d  = w_word;
          sum_d   = sum_q + w_word32;
        end
      end
      S_CKSUM: begin
        if (w_xfer) begin
          field_d = w_field[31:8];
          bcnt_d  = bcnt_q + 2'd1;
          if (bcnt_q == LAST_FIELD) state_d = (w_field == sum_q) ? S_DONE : S_ERR;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LEN;
      bcnt_q  <= '0;
      field_q <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      sum_q   <= '0;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      write_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      core_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      field_q <= field_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      sum_q   <= sum_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      busy_q  <= (state_d == S_LEN) || (state_d == S_LOAD) || (state_d == S_CKSUM);
      err_q   <= (state_d == S_ERR);
      core_q  <= (state_d == S_DONE);
    end
  end

  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign mem_write_o  = write_q;
  assign core_rst_n_o = core_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_inst_loader : directed frames checked against an expected image    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_inst_loader;

  localparam int              WORD = 32;
  localparam int              ADDR = 16;
  localparam logic [ADDR-1:0] BASE = '0;
`ifdef INST_LOADER_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [7:0]      byte_i = '0;
  logic            byte_valid_i = 1'b0;
  logic            byte_ready_o;
  logic [ADDR-1:0] mem_addr_o;
  logic [WORD-1:0] mem_data_o;
  logic            mem_write_o;
  logic            core_rst_n_o;
  logic            busy_o;
  logic            err_o;

  always #5 clk = ~clk;

  inst_loader #(.WORD(WORD), .ADDR(ADDR), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_write_o  (mem_write_o),
    .core_rst_n_o (core_rst_n_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  int              pass_cnt = 0;
  int              total_cnt = 0;
  int              nwrites = 0;
  logic [ADDR-1:0] exp_a[$];
  logic [WORD-1:0] exp_d[$];
  logic [31:0]     words[$];
  logic [ADDR-1:0] last_a;
  logic [WORD-1:0] last_d;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Expected memory image is a queue of (address, word) built from the frame contents
  always @(negedge clk) begin
    if (reset) begin
      if (mem_write_o) begin
        nwrites++;
        last_a = mem_addr_o;
        last_d = mem_data_o;
        chk("write_expected", exp_a.size() > 0, 1);
        if (exp_a.size() > 0) begin
          chk("wr_addr", mem_addr_o, exp_a.pop_front());
          chk("wr_data", mem_data_o, exp_d.pop_front());
        end
      end
      if (mem_write_o || core_rst_n_o || err_o) chk("ready_low", byte_ready_o, 0);
      if (core_rst_n_o) begin
        chk("release_after_all_writes", exp_a.size(), 0);
        chk("release_without_err", err_o, 0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      byte_valid_i = 1'b0;
      @(negedge clk);
    end
    byte_valid_i = 1'b1;
    byte_i       = b;
    t = 0;
    while (!byte_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready_o) begin
      total_cnt++;
      $display("FAIL byte_accept_timeout: byte 0x%0h not accepted after %0d cycles", b, t);
      byte_valid_i = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send32(input logic [31:0] v, input int maxgap);
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], int'($urandom_range(0, maxgap)));
  endtask

  task automatic send_frame(input logic [31:0] len, input int maxgap,
                            input logic [31:0] ck_delta, input bit send_ck);
    logic [31:0] sum;
    sum = '0;
    send32(len, maxgap);
    for (int i = 0; i < words.size(); i++) begin
      exp_a.push_back(BASE + ADDR'(i));
      exp_d.push_back(words[i]);
      sum += words[i];
      send32(words[i], maxgap);
    end
    if (CK_EN && send_ck) send32(sum + ck_delta, maxgap);
    byte_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    byte_valid_i = 1'b0;
    exp_a.delete();
    exp_d.delete();
    repeat (2) @(negedge clk);
    nwrites = 0;
    reset   = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic final_check(input string tag, input bit exp_core, input bit exp_err,
                             input int exp_writes);
    repeat (3) @(negedge clk);
    chk({tag, "_core_rst_n"}, core_rst_n_o, exp_core);
    chk({tag, "_err"}, err_o, exp_err);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_ready"}, byte_ready_o, 0);
    chk({tag, "_writes"}, nwrites, exp_writes);
    chk({tag, "_pending"}, exp_a.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_write", mem_write_o, 0);
    chk("rst_addr", mem_addr_o, BASE);
    chk("rst_data", mem_data_o, 0);
    chk("rst_core", core_rst_n_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_ready", byte_ready_o, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy_o, 1);
    chk("idle_ready", byte_ready_o, 1);

    // three literal words, back-to-back bytes so a byte waits through each bubble
    words = '{32'h11223344, 32'hAABBCCDD, 32'h00000001};
    send_frame(32'd3, 0, 32'd0, 1'b1);
    final_check("t1", 1'b1, 1'b0, 3);
    chk("t1_last_addr", last_a, 16'd2);
    chk("t1_last_data", last_d, 32'h00000001);

    // empty image
    do_reset();
    words.delete();
    send_frame(32'd0, 0, 32'd0, 1'b1);
`ifndef INST_LOADER_CKSUM_EN
    chk("t2_core_immediate", core_rst_n_o, 1);
`endif
    final_check("t2", 1'b1, 1'b0, 0);

    // random words with random valid gaps
    do_reset();
    words.delete();
    for (int i = 0; i < 20; i++) words.push_back($urandom);
    send_frame(32'd20, 3, 32'd0, 1'b1);
    final_check("t3", 1'b1, 1'b0, 20);

    // length one past the address space
    do_reset();
    words.delete();
    send_frame(32'h0001_0001, 1, 32'd0, 1'b0);
    final_check("t4", 1'b0, 1'b1, 0);

    // reset after five of eight words, then a full resend
    do_reset();
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back($urandom);
    send32(32'd8, 0);
    for (int i = 0; i < 5; i++) begin
      exp_a.push_back(BASE + ADDR'(i));
      exp_d.push_back(words[i]);
      send32(words[i], 1);
    end
    send_byte(words[5][7:0], 0);
    repeat (2) @(negedge clk);
    chk("t5_partial_writes", nwrites, 5);
    #2;
    reset        = 1'b0;
    byte_valid_i = 1'b0;
    #1;
    chk("t5_abort_write", mem_write_o, 0);
    chk("t5_abort_addr", mem_addr_o, BASE);
    chk("t5_abort_busy", busy_o, 0);
    chk("t5_abort_ready", byte_ready_o, 0);
    chk("t5_abort_core", core_rst_n_o, 0);
    do_reset();
    send_frame(32'd8, 1, 32'd0, 1'b1);
    final_check("t5", 1'b1, 1'b0, 8);

`ifdef INST_LOADER_CKSUM_EN
    // checksum off by one
    do_reset();
    words = '{32'h0000_0010, 32'hFFFF_FFF0};
    send_frame(32'd2, 0, 32'd1, 1'b1);
    final_check("t6", 1'b0, 1'b1, 2);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
